// File: rtl/hc02_tester_pkg.sv
// Shared types and constants for the quad 2-input NOR (74HC02) tester.
// Holds the FSM encoding, the four-entry stimulus table and the error counter width.
package hc02_tester_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int ERR_W   = 8;
  localparam int NUM_VEC = 4;

  // Bit i of each table is the value for vector index i: (a,b) = 00,01,10,11.
  localparam logic [NUM_VEC-1:0] VEC_A = 4'b1100;
  localparam logic [NUM_VEC-1:0] VEC_B = 4'b1010;
  localparam logic [NUM_VEC-1:0] VEC_Y = 4'b0001;

  function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] acc, input logic [31:0] inc);
    logic [31:0] sum;
    logic [31:0] max_v;
    sum   = {{(32-ERR_W){1'b0}}, acc} + inc;
    max_v = {{(32-ERR_W){1'b0}}, {ERR_W{1'b1}}};
    if (sum > max_v) begin
      return {ERR_W{1'b1}};
    end else begin
      return sum[ERR_W-1:0];
    end
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer with synchronous reset for asynchronous input pins.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Metastability stage followed by the stable output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= '0;
      sync_r <= '0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/hc02_tester.sv
// Drives all four NOR truth-table vectors into GATES parallel gates, samples the
// synchronized outputs after a settle window and accumulates per-gate mismatches.
module hc02_tester
  import hc02_tester_pkg::*;
#(
  parameter int GATES         = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [GATES-1:0] drive_a,
  output logic [GATES-1:0] drive_b,
  input  logic [GATES-1:0] sense_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [GATES-1:0] fail_mask,
  output logic [ERR_W-1:0] err_count
);

  // Nine bits so that SETTLE_CYCLES=255 still reloads as 256.
  localparam logic [8:0] CNT_LOAD = 9'(SETTLE_CYCLES + 1);

  state_t           state_r, state_s;
  logic [1:0]       idx_r, idx_s;
  logic [8:0]       cnt_r, cnt_s;
  logic [GATES-1:0] drive_a_r, drive_a_s;
  logic [GATES-1:0] drive_b_r, drive_b_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             pass_r, pass_s;
  logic [GATES-1:0] fail_mask_r, fail_mask_s;
  logic [ERR_W-1:0] err_count_r, err_count_s;
  logic [GATES-1:0] sense_sync_s;
  logic [GATES-1:0] mismatch_s;

  function automatic logic [31:0] popcount(input logic [GATES-1:0] v);
    logic [31:0] n;
    n = 32'd0;
    for (int i = 0; i < GATES; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

  sync2 #(.WIDTH(GATES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sense_y),
    .q   (sense_sync_s)
  );

  // Next-state, datapath update and next values of the registered outputs.
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    cnt_s       = cnt_r;
    fail_mask_s = fail_mask_r;
    err_count_s = err_count_r;
    pass_s      = pass_r;
    mismatch_s  = '0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          idx_s       = 2'd0;
          cnt_s       = CNT_LOAD;
          fail_mask_s = '0;
          err_count_s = '0;
          pass_s      = 1'b0;
          state_s     = ST_SETTLE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_r == 9'd0) begin
          state_s = ST_SAMPLE;
        end else begin
          cnt_s = cnt_r - 9'd1;
        end
      end
      ST_SAMPLE: begin
        mismatch_s  = sense_sync_s ^ {GATES{VEC_Y[idx_r]}};
        fail_mask_s = fail_mask_r | mismatch_s;
        err_count_s = sat_add(err_count_r, popcount(mismatch_s));
        if (idx_r != 2'd3) begin
          idx_s   = idx_r + 2'd1;
          cnt_s   = CNT_LOAD;
          state_s = ST_SETTLE;
        end else begin
          // pass must already reflect the final sample while done is high
          pass_s  = (fail_mask_s == '0);
          state_s = ST_DONE;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    busy_s = (state_s != ST_IDLE);
    done_s = (state_s == ST_DONE);
    if ((state_s == ST_SETTLE) || (state_s == ST_SAMPLE)) begin
      drive_a_s = {GATES{VEC_A[idx_s]}};
      drive_b_s = {GATES{VEC_B[idx_s]}};
    end else begin
      drive_a_s = '0;
      drive_b_s = '0;
    end
  end

  // State, sequencing and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      idx_r       <= 2'd0;
      cnt_r       <= 9'd0;
      drive_a_r   <= '0;
      drive_b_r   <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      fail_mask_r <= '0;
      err_count_r <= '0;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      cnt_r       <= cnt_s;
      drive_a_r   <= drive_a_s;
      drive_b_r   <= drive_b_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      pass_r      <= pass_s;
      fail_mask_r <= fail_mask_s;
      err_count_r <= err_count_s;
    end
  end

  assign drive_a   = drive_a_r;
  assign drive_b   = drive_b_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign fail_mask = fail_mask_r;
  assign err_count = err_count_r;

endmodule
